ctrl_unit_pipe: RTL and testbench

- Parametrised, registered successor of the ID-stage controller.
- Decodes one opcode per cycle into a registered ID/EX control bundle.
- Holds a persistent Z/N condition-flag register written by CMP, and resolves BNE/BEQ/BLT/JMP against it.
- Sequences a multi-cycle MULT by stalling the front end.
- Sits between the IF/ID register and the ID/EX register; its outputs are the ID/EX control fields.

---
 rtl/ctrl_unit_pipe.sv | 164 ++++++++++++++++
 tb/tb_ctrl_unit_pipe.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/ctrl_unit_pipe.sv
// ID-stage controller: decodes one opcode per cycle into a registered ID/EX
// control bundle, owns the Z/N flag register and stalls the front end during MULT.
module ctrl_unit_pipe #(
  parameter int WORD_LEN    = 16,
  parameter int OP_CODE_LEN = 4,
  parameter int EXE_CMD_LEN = 4,
  parameter int MULT_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [OP_CODE_LEN-1:0] op_code,
  input  logic [WORD_LEN-1:0]    src1,
  input  logic [WORD_LEN-1:0]    src2,
  input  logic                   hazard_detected,
  output logic [EXE_CMD_LEN-1:0] exe_cmd,
  output logic                   wb_en,
  output logic                   mem_r_en,
  output logic                   mem_w_en,
  output logic                   is_imm,
  output logic                   st_or_bne,
  output logic                   branch_taken,
  output logic                   jump_en,
  output logic                   illegal_op,
  output logic                   z_flag,
  output logic                   n_flag,
  output logic                   stall_out
);

  localparam int CNT_W = (MULT_CYCLES > 2) ? $clog2(MULT_CYCLES - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((MULT_CYCLES > 1) ? MULT_CYCLES - 2 : 0);

  localparam logic [EXE_CMD_LEN-1:0] CMD_NOP  = EXE_CMD_LEN'(0);
  localparam logic [EXE_CMD_LEN-1:0] CMD_ADD  = EXE_CMD_LEN'(1);
  localparam logic [EXE_CMD_LEN-1:0] CMD_SUB  = EXE_CMD_LEN'(2);
  localparam logic [EXE_CMD_LEN-1:0] CMD_AND  = EXE_CMD_LEN'(3);
  localparam logic [EXE_CMD_LEN-1:0] CMD_MULT = EXE_CMD_LEN'(4);
  localparam logic [EXE_CMD_LEN-1:0] CMD_SLL  = EXE_CMD_LEN'(5);

  typedef enum logic {IDLE, MUL_BUSY} state_t;

  typedef struct packed {
    logic [EXE_CMD_LEN-1:0] exe_cmd;
    logic                   wb_en;
    logic                   mem_r_en;
    logic                   mem_w_en;
    logic                   is_imm;
    logic                   st_or_bne;
    logic                   branch_taken;
    logic                   jump_en;
    logic                   illegal_op;
  } ctrl_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic             z_q, z_d, n_q, n_d;
  logic             stall_q, stall_d;

  logic [WORD_LEN:0] diff;
  logic [3:0]        op4;
  logic              op_hi_bad;

  // Sign-extend both operands by one bit so the subtraction cannot overflow.
  assign diff      = {src1[WORD_LEN-1], src1} - {src2[WORD_LEN-1], src2};
  assign op4       = op_code[3:0];
  assign op_hi_bad = (op_code >> 4) != '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl_d  = '0;
    z_d     = z_q;
    n_d     = n_q;
    stall_d = stall_q;

    if (state_q == MUL_BUSY) begin
      if (cnt_q == '0) begin
        state_d = IDLE;
        stall_d = 1'b0;
      end else begin
        cnt_d   = cnt_q - CNT_W'(1);
        stall_d = 1'b1;
      end
    end else if (!hazard_detected) begin
      if (op_hi_bad) begin
        ctrl_d.illegal_op = 1'b1;
      end else begin
        unique case (op4)
          4'h0: ;
          4'h1: begin ctrl_d.exe_cmd = CMD_ADD; ctrl_d.wb_en = 1'b1; end
          4'h2: begin ctrl_d.exe_cmd = CMD_SUB; ctrl_d.wb_en = 1'b1; end
          4'h3: begin ctrl_d.exe_cmd = CMD_AND; ctrl_d.wb_en = 1'b1; end
          4'h4: begin
            ctrl_d.exe_cmd = CMD_MULT;
            ctrl_d.wb_en   = 1'b1;
            if (MULT_CYCLES > 1) begin
              state_d = MUL_BUSY;
              cnt_d   = CNT_INIT;
              stall_d = 1'b1;
            end
          end
          4'h5: begin ctrl_d.exe_cmd = CMD_SLL; ctrl_d.wb_en = 1'b1; end
          4'h6: begin ctrl_d.exe_cmd = CMD_ADD; ctrl_d.wb_en = 1'b1; ctrl_d.is_imm = 1'b1; end
          4'h7: begin
            ctrl_d.exe_cmd   = CMD_ADD;
            ctrl_d.wb_en     = 1'b1;
            ctrl_d.is_imm    = 1'b1;
            ctrl_d.st_or_bne = 1'b1;
            ctrl_d.mem_r_en  = 1'b1;
          end
          4'h8: begin
            ctrl_d.exe_cmd   = CMD_ADD;
            ctrl_d.is_imm    = 1'b1;
            ctrl_d.st_or_bne = 1'b1;
            ctrl_d.mem_w_en  = 1'b1;
          end
          4'h9: begin
            ctrl_d.exe_cmd = CMD_NOP;
            z_d = (diff == '0);
            n_d = diff[WORD_LEN];
          end
          // Branches resolve against the flag register as it stands now.
          4'hA: begin ctrl_d.is_imm = 1'b1; ctrl_d.st_or_bne = 1'b1; ctrl_d.branch_taken = ~z_q; end
          4'hB: begin ctrl_d.is_imm = 1'b1; ctrl_d.st_or_bne = 1'b1; ctrl_d.branch_taken = z_q; end
          4'hC: begin ctrl_d.is_imm = 1'b1; ctrl_d.branch_taken = n_q; end
          4'hD: begin ctrl_d.is_imm = 1'b1; ctrl_d.branch_taken = 1'b1; ctrl_d.jump_en = 1'b1; end
          default: ctrl_d.illegal_op = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ctrl_q  <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      z_q     <= z_d;
      n_q     <= n_d;
      stall_q <= stall_d;
    end
  end

  assign exe_cmd      = ctrl_q.exe_cmd;
  assign wb_en        = ctrl_q.wb_en;
  assign mem_r_en     = ctrl_q.mem_r_en;
  assign mem_w_en     = ctrl_q.mem_w_en;
  assign is_imm       = ctrl_q.is_imm;
  assign st_or_bne    = ctrl_q.st_or_bne;
  assign branch_taken = ctrl_q.branch_taken;
  assign jump_en      = ctrl_q.jump_en;
  assign illegal_op   = ctrl_q.illegal_op;
  assign z_flag       = z_q;
  assign n_flag       = n_q;
  assign stall_out    = stall_q;

endmodule

// File: tb/tb_ctrl_unit_pipe.sv
// Scoreboard bench for ctrl_unit_pipe: directed opcodes push hand-computed
// bundles; a negedge monitor pops and compares every registered output.
module tb_ctrl_unit_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  op_code = '0;
  logic [15:0] src1 = '0, src2 = '0;
  logic        hazard_detected = 1'b0;
  logic [3:0]  exe_cmd;
  logic        wb_en, mem_r_en, mem_w_en, is_imm, st_or_bne;
  logic        branch_taken, jump_en, illegal_op, z_flag, n_flag, stall_out;

  typedef struct packed {
    logic [3:0] exe;
    logic wb, mr, mw, imm, sob, br, jmp, ill, z, n, st;
  } exp_t;

  typedef struct {
    exp_t  e;
    string nm;
  } sb_t;

  sb_t  sb[$];
  exp_t act;
  int   checks = 0;
  int   errors = 0;

  ctrl_unit_pipe #(.WORD_LEN(16), .OP_CODE_LEN(4), .EXE_CMD_LEN(4), .MULT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .op_code(op_code), .src1(src1), .src2(src2),
    .hazard_detected(hazard_detected), .exe_cmd(exe_cmd), .wb_en(wb_en),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .is_imm(is_imm), .st_or_bne(st_or_bne),
    .branch_taken(branch_taken), .jump_en(jump_en), .illegal_op(illegal_op),
    .z_flag(z_flag), .n_flag(n_flag), .stall_out(stall_out)
  );

  always #5 clk = ~clk;

  assign act = {exe_cmd, wb_en, mem_r_en, mem_w_en, is_imm, st_or_bne,
                branch_taken, jump_en, illegal_op, z_flag, n_flag, stall_out};

  function automatic exp_t mk(input logic [3:0] exe, input logic wb, mr, mw, imm, sob,
                              br, jmp, ill, z, n, st);
    return '{exe: exe, wb: wb, mr: mr, mw: mw, imm: imm, sob: sob, br: br,
             jmp: jmp, ill: ill, z: z, n: n, st: st};
  endfunction

  task automatic check(input string nm, input exp_t e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got exe=%0d wb/mr/mw/imm/sob/br/jmp/ill/z/n/st=%b  expected exe=%0d %b",
               nm, act.exe, act[10:0], e.exe, e[10:0]);
    end
  endtask

  // Drive one instruction; its expected bundle becomes visible after this edge.
  task automatic step(input string nm, input logic [3:0] op, input logic [15:0] a,
                      input logic [15:0] b, input logic hz, input exp_t e);
    sb_t it;
    op_code = op; src1 = a; src2 = b; hazard_detected = hz;
    @(posedge clk);
    it.e = e; it.nm = nm;
    sb.push_back(it);
    #1;
  endtask

  initial begin : monitor
    sb_t it;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        it = sb.pop_front();
        check(it.nm, it.e);
      end
    end
  end

  localparam exp_t Z0 = '0;

  initial begin : driver
    repeat (2) @(posedge clk);
    #1 check("reset_state", Z0);
    rst = 1'b0;

    step("add",      4'h1, 16'd0,    16'd0,    1'b0, mk(4'd1,1,0,0,0,0,0,0,0,0,0,0));
    step("lw",       4'h7, 16'd0,    16'd0,    1'b0, mk(4'd1,1,1,0,1,1,0,0,0,0,0,0));
    step("sw",       4'h8, 16'd0,    16'd0,    1'b0, mk(4'd1,0,0,1,1,1,0,0,0,0,0,0));
    step("cmp_eq",   4'h9, 16'd5,    16'd5,    1'b0, mk(4'd0,0,0,0,0,0,0,0,0,1,0,0));
    step("beq_t",    4'hB, 16'd0,    16'd0,    1'b0, mk(4'd0,0,0,0,1,1,1,0,0,1,0,0));
    step("cmp_neg",  4'h9, 16'hFFFE, 16'd3,    1'b0, mk(4'd0,0,0,0,0,0,0,0,0,0,1,0));
    step("blt_t",    4'hC, 16'd0,    16'd0,    1'b0, mk(4'd0,0,0,0,1,0,1,0,0,0,1,0));
    step("bne_t",    4'hA, 16'd0,    16'd0,    1'b0, mk(4'd0,0,0,0,1,1,1,0,0,0,1,0));
    step("cmp_ovf",  4'h9, 16'h7FFF, 16'h8000, 1'b0, mk(4'd0,0,0,0,0,0,0,0,0,0,0,0));
    step("blt_nt",   4'hC, 16'd0,    16'd0,    1'b0, mk(4'd0,0,0,0,1,0,0,0,0,0,0,0));
    step("cmp_lt",   4'h9, 16'd1,    16'd2,    1'b0, mk(4'd0,0,0,0,0,0,0,0,0,0,1,0));
    step("cmp_hz",   4'h9, 16'd4,    16'd4,    1'b1, mk(4'd0,0,0,0,0,0,0,0,0,0,1,0));
    step("bne_hz",   4'hA, 16'd0,    16'd0,    1'b1, mk(4'd0,0,0,0,0,0,0,0,0,0,1,0));
    step("jmp",      4'hD, 16'd0,    16'd0,    1'b0, mk(4'd0,0,0,0,1,0,1,1,0,0,1,0));
    step("ill_e",    4'hE, 16'd0,    16'd0,    1'b0, mk(4'd0,0,0,0,0,0,0,0,1,0,1,0));
    step("nop",      4'h0, 16'd0,    16'd0,    1'b0, mk(4'd0,0,0,0,0,0,0,0,0,0,1,0));
    step("ill_f",    4'hF, 16'd0,    16'd0,    1'b0, mk(4'd0,0,0,0,0,0,0,0,1,0,1,0));
    step("mult_hz",  4'h4, 16'd0,    16'd0,    1'b1, mk(4'd0,0,0,0,0,0,0,0,0,0,1,0));
    step("mult",     4'h4, 16'd0,    16'd0,    1'b0, mk(4'd4,1,0,0,0,0,0,0,0,0,1,1));
    step("busy_cmp", 4'h9, 16'd7,    16'd7,    1'b0, mk(4'd0,0,0,0,0,0,0,0,0,0,1,1));
    step("busy_add", 4'h1, 16'd0,    16'd0,    1'b0, mk(4'd0,0,0,0,0,0,0,0,0,0,1,1));
    step("busy_end", 4'h1, 16'd0,    16'd0,    1'b0, mk(4'd0,0,0,0,0,0,0,0,0,0,1,0));
    step("add_post", 4'h1, 16'd0,    16'd0,    1'b0, mk(4'd1,1,0,0,0,0,0,0,0,0,1,0));
    step("mult_a",   4'h4, 16'd0,    16'd0,    1'b0, mk(4'd4,1,0,0,0,0,0,0,0,0,1,1));
    step("mult_a_b1",4'h4, 16'd0,    16'd0,    1'b0, mk(4'd0,0,0,0,0,0,0,0,0,0,1,1));
    step("mult_a_b2",4'h4, 16'd0,    16'd0,    1'b0, mk(4'd0,0,0,0,0,0,0,0,0,0,1,1));
    step("mult_a_b3",4'h4, 16'd0,    16'd0,    1'b0, mk(4'd0,0,0,0,0,0,0,0,0,0,1,0));
    step("mult_b",   4'h4, 16'd0,    16'd0,    1'b0, mk(4'd4,1,0,0,0,0,0,0,0,0,1,1));
    step("mult_b_b1",4'h0, 16'd0,    16'd0,    1'b0, mk(4'd0,0,0,0,0,0,0,0,0,0,1,1));

    // Asynchronous reset in the middle of the busy window.
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check("async_rst", Z0);
    @(posedge clk);
    #1 check("rst_hold", Z0);
    rst = 1'b0;

    step("mult_r",   4'h4, 16'd0,    16'd0,    1'b0, mk(4'd4,1,0,0,0,0,0,0,0,0,0,1));
    step("mult_r_b1",4'h0, 16'd0,    16'd0,    1'b0, mk(4'd0,0,0,0,0,0,0,0,0,0,0,1));
    step("mult_r_b2",4'h0, 16'd0,    16'd0,    1'b0, mk(4'd0,0,0,0,0,0,0,0,0,0,0,1));
    step("mult_r_b3",4'h0, 16'd0,    16'd0,    1'b0, mk(4'd0,0,0,0,0,0,0,0,0,0,0,0));
    step("sub",      4'h2, 16'd0,    16'd0,    1'b0, mk(4'd2,1,0,0,0,0,0,0,0,0,0,0));
    step("and",      4'h3, 16'd0,    16'd0,    1'b0, mk(4'd3,1,0,0,0,0,0,0,0,0,0,0));
    step("sll",      4'h5, 16'd0,    16'd0,    1'b0, mk(4'd5,1,0,0,0,0,0,0,0,0,0,0));
    step("addi",     4'h6, 16'd0,    16'd0,    1'b0, mk(4'd1,1,0,0,1,0,0,0,0,0,0,0));
    op_code = 4'h0;

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
